fft_data_input: RTL and testbench

- Transmit-side counterpart of the FFT output capture buffer.
- Software or a bus bridge fills a 2*NFFT x 32-bit sample RAM through a simple write port. RE words go at even addresses, IM words at odd addresses.
- On a start pulse, the block streams the NFFT complex samples to the FFT core over an AXI4-Stream master interface, with tlast on the final sample.

---
 rtl/fft_data_input.sv | 141 ++++++++++++++
 tb/tb_fft_data_input.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_data_input.sv
// fft_data_input: streams a frame of NFFT complex samples from a RAM over AXI4-Stream.
// Latency: first beat valid 1 cycle after start; then one beat per cycle while tready is high.
// Backpressure: tvalid/tdata/tlast hold until tready; the RAM is write-protected while a frame is in flight.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   wAddr, wData, wEn     RAM write port (even address = RE, odd address = IM of sample wAddr>>1)
//   start                 frame request, accepted only when idle
//   tvalid/tready/tlast/tdata   AXIS master, tdata = {IM, RE}
//   sending, done         frame in progress / one-cycle pulse after the last beat is accepted
//   stall_count           (only with FFT_DATA_INPUT_STALL_CNT_EN) backpressure cycles of the current or last frame
//
// Optional feature macro: FFT_DATA_INPUT_STALL_CNT_EN

module fft_data_input #(
  parameter int NFFT = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [$clog2(NFFT*2)-1:0] wAddr,
  input  logic [31:0]               wData,
  input  logic                      wEn,
  input  logic                      start,
  output logic                      tvalid,
  input  logic                      tready,
  output logic                      tlast,
  output logic [63:0]               tdata,
  output logic                      sending,
  output logic                      done
`ifdef FFT_DATA_INPUT_STALL_CNT_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  localparam int AW = $clog2(NFFT*2);
  localparam int IW = $clog2(NFFT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NFFT-1);

  typedef enum logic {IDLE, SENDING} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [IW-1:0]  idx_inc;
  logic           tvalid_nxt, tlast_nxt, sending_nxt, done_nxt;
  logic [63:0]    tdata_nxt;
  logic           start_acc;
  logic [31:0]    re0, im0;
  logic [AW-1:0]  rd_re, rd_im;

  logic [31:0]    ram [0:2*NFFT-1];

  // RAM has no reset: contents survive resetn so a frame can be resent.
  always_ff @(posedge clk) begin
    if (wEn && state == IDLE) begin
      ram[wAddr] <= wData;
    end
  end

  // First beat is write-first: a same-cycle write to sample 0 is forwarded.
  assign re0 = (wEn && wAddr == AW'(0)) ? wData : ram[0];
  assign im0 = (wEn && wAddr == AW'(1)) ? wData : ram[1];

  assign idx_inc = idx + 1'b1;
  assign rd_re   = {idx_inc, 1'b0};
  assign rd_im   = {idx_inc, 1'b1};

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    tvalid_nxt  = tvalid;
    tlast_nxt   = tlast;
    tdata_nxt   = tdata;
    sending_nxt = sending;
    done_nxt    = 1'b0;
    start_acc   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc   = 1'b1;
          tdata_nxt   = {im0, re0};
          tvalid_nxt  = 1'b1;
          tlast_nxt   = 1'b0;  // NFFT >= 2, so sample 0 is never the last
          idx_nxt     = '0;
          sending_nxt = 1'b1;
          state_nxt   = SENDING;
        end
      end
      SENDING: begin
        if (tvalid && tready) begin
          if (idx == LAST_IDX) begin
            tvalid_nxt  = 1'b0;
            tlast_nxt   = 1'b0;
            sending_nxt = 1'b0;
            done_nxt    = 1'b1;
            state_nxt   = IDLE;
          end else begin
            idx_nxt   = idx_inc;
            tdata_nxt = {ram[rd_im], ram[rd_re]};
            tlast_nxt = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      tvalid  <= 1'b0;
      tlast   <= 1'b0;
      tdata   <= '0;
      sending <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      tvalid  <= tvalid_nxt;
      tlast   <= tlast_nxt;
      tdata   <= tdata_nxt;
      sending <= sending_nxt;
      done    <= done_nxt;
    end
  end

`ifdef FFT_DATA_INPUT_STALL_CNT_EN
  // Held in IDLE so the previous frame's backpressure stays readable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_count <= '0;
    end else if (start_acc) begin
      stall_count <= '0;
    end else if (state == SENDING && tvalid && !tready && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_data_input.sv
module tb_fft_data_input;

  localparam int NFFT = 8;
  localparam int AW   = $clog2(NFFT*2);

  logic          clk;
  logic          resetn;
  logic [AW-1:0] wAddr;
  logic [31:0]   wData;
  logic          wEn;
  logic          start;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [63:0]   tdata;
  logic          sending;
  logic          done;
`ifdef FFT_DATA_INPUT_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  fft_data_input #(.NFFT(NFFT)) dut (
    .clk(clk), .resetn(resetn), .wAddr(wAddr), .wData(wData), .wEn(wEn),
    .start(start), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .tdata(tdata), .sending(sending), .done(done)
`ifdef FFT_DATA_INPUT_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        tready;
    logic        e_vld;
    logic        e_last;
    logic [63:0] e_dat;
    logic        e_snd;
    logic        e_done;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mem[2*NFFT];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] smp(input int i);
    logic [31:0] re, im;
    re = 32'(i);
    im = 32'h100 + 32'(i);
    return {im, re};
  endfunction

  function automatic void push(input logic s, input logic r, input logic v, input logic l,
                               input logic [63:0] d, input logic sn, input logic dn);
    vec_t x;
    x.start = s; x.tready = r; x.e_vld = v; x.e_last = l; x.e_dat = d; x.e_snd = sn; x.e_done = dn;
    vecs.push_back(x);
  endfunction

  // IDLE write; the model is only updated for writes the block must accept.
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    wEn = 1'b1; wAddr = a; wData = d;
    step();
    wEn = 1'b0;
    mem[a] = d;
  endtask

  // Starts a frame and drains it with tready=1. wr_cyc >= 0 issues a write at that
  // cycle of the frame (must be ignored); wr_cyc == -2 writes in the start cycle.
  task automatic run_frame(input int wr_cyc, input logic [AW-1:0] wa, input logic [31:0] wd,
                           input int st0, input int st1, input string tag);
    logic [63:0] bt[NFFT];
    logic        bl[NFFT];
    int          nb, ndone, post;
    logic        late, seen;
    nb = 0; ndone = 0; post = 0; late = 1'b0; seen = 1'b0;
    if (wr_cyc == -2) begin
      wEn = 1'b1; wAddr = wa; wData = wd;
      mem[wa] = wd;
    end
    tready = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    wEn   = 1'b0;
    for (int c = 0; c < 40 && post < 4; c++) begin
      wEn   = (c == wr_cyc);
      wAddr = wa;
      wData = wd;
      start = (c == st0 || c == st1);
      if (tvalid) begin
        if (seen) late = 1'b1;
        else if (nb < NFFT) begin
          bt[nb] = tdata;
          bl[nb] = tlast;
          nb++;
        end
      end
      step();
      if (done) begin
        ndone++;
        seen = 1'b1;
      end
      if (seen) post++;
    end
    wEn = 1'b0;
    start = 1'b0;
    chk({tag, "_beats"}, 64'(nb), 64'(NFFT));
    chk({tag, "_done_cnt"}, 64'(ndone), 64'd1);
    chk({tag, "_extra_frame"}, 64'(late), 64'd0);
    chk({tag, "_sending_after"}, 64'(sending), 64'd0);
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s_beat%0d_data", tag, i), bt[i], {mem[2*i+1], mem[2*i]});
      chk($sformatf("%s_beat%0d_last", tag, i), 64'(bl[i]), 64'(i == NFFT-1));
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; wEn = 1'b0; tready = 1'b0; wAddr = '0; wData = '0;

    // Frame 0 streams without stalls; frame 1 starts in the cycle right after
    // done and sees 3 stall cycles at beat 2 and 5 at beat 6.
    for (int f = 0; f < 2; f++) begin
      push(1, 1, 1, 0, smp(0), 1, 0);
      for (int b = 0; b < NFFT; b++) begin
        int ns;
        ns = (f == 1 && b == 2) ? 3 : (f == 1 && b == 6) ? 5 : 0;
        for (int s = 0; s < ns; s++) push(0, 0, 1, b == NFFT-1, smp(b), 1, 0);
        if (b < NFFT-1) push(0, 1, 1, b+1 == NFFT-1, smp(b+1), 1, 0);
        else            push(0, 1, 0, 0, 64'h0, 0, 1);
      end
    end
    push(0, 1, 0, 0, 64'h0, 0, 0);
    push(0, 0, 0, 0, 64'h0, 0, 0);

    step();
    step();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_sending", 64'(sending), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
`ifdef FFT_DATA_INPUT_STALL_CNT_EN
    chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
    resetn = 1'b1;
    step();

    for (int i = 0; i < NFFT; i++) begin
      wr(AW'(2*i), 32'(i));
      wr(AW'(2*i+1), 32'h100 + 32'(i));
    end

    for (int k = 0; k < vecs.size(); k++) begin
      start  = vecs[k].start;
      tready = vecs[k].tready;
      step();
      chk($sformatf("vec%0d_tvalid", k), 64'(tvalid), 64'(vecs[k].e_vld));
      chk($sformatf("vec%0d_tlast", k), 64'(tlast), 64'(vecs[k].e_last));
      chk($sformatf("vec%0d_sending", k), 64'(sending), 64'(vecs[k].e_snd));
      chk($sformatf("vec%0d_done", k), 64'(done), 64'(vecs[k].e_done));
      if (vecs[k].e_vld) chk($sformatf("vec%0d_tdata", k), tdata, vecs[k].e_dat);
    end
    start = 1'b0;
`ifdef FFT_DATA_INPUT_STALL_CNT_EN
    chk("bp_stall_count", 64'(stall_count), 64'd8);
`endif

    // Write protection during SENDING, then an accepted IDLE write.
    run_frame(0, AW'(4), 32'hDEADBEEF, -1, -1, "wp_busy");
    run_frame(-1, AW'(4), 32'hDEADBEEF, -1, -1, "wp_again");
    wr(AW'(4), 32'hDEADBEEF);
    run_frame(-1, '0, '0, -1, -1, "wp_idle");
    chk("wp_idle_beat2_re", 64'(mem[4]), 64'hDEADBEEF);
    wr(AW'(4), 32'd2);

    // start pulses while busy are ignored.
    run_frame(-1, '0, '0, 3, 7, "busy");

    // Reset after beat 4 is accepted.
    tready = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("mid_beat5_data", tdata, {mem[11], mem[10]});
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_sending", 64'(sending), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    step();
    chk("mid_post_done", 64'(done), 64'd0);
    chk("mid_post_tvalid", 64'(tvalid), 64'd0);
    run_frame(-1, '0, '0, -1, -1, "after_rst");

    // Same-cycle write to address 0 and start: first beat carries the new word.
    run_frame(-2, '0, 32'h55, -1, -1, "wr_start");
    chk("wr_start_model_re0", 64'(mem[0]), 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
